// File: rtl/gb_cpu_common_pkg.sv
// Shared types for the gb_cpu core: control word, per-opcode M-cycle
// schedule, schedule depth and sequencer state enum.
package gb_cpu_common_pkg;

   localparam int MAX_M_CYCLES = 6;

   typedef struct packed {
      logic [3:0] alu_op;
      logic [2:0] reg_src;
      logic [2:0] reg_dst;
      logic       reg_we;
      logic       mem_rd;
      logic       mem_wr;
      logic [1:0] addr_sel;
      logic       pc_inc;
   } control_t;

   typedef struct packed {
      logic [2:0]                       num_m_cycles;
      control_t [MAX_M_CYCLES-1:0]      m_cycles;
   } schedule_t;

   typedef enum logic {
      EXEC = 1'b0,
      HALT = 1'b1
   } seq_state_t;

   // Index of the final M-cycle; a zero-length schedule still takes one.
   function automatic logic [2:0] last_index(logic [2:0] num);
      return (num == 3'd0) ? 3'd0 : 3'(num - 3'd1);
   endfunction

endpackage

// File: rtl/gb_cpu_sequencer_if.sv
// Bundle between the sequencer and the decoder/datapath.
// master: sequencer side (drives opcode/ctrl); slave: decoder/datapath side.
interface gb_cpu_sequencer_if;
   import gb_cpu_common_pkg::*;

   schedule_t  schedule;
   logic [7:0] mem_rdata;
   logic       int_pending;
   logic       ime;
   logic [7:0] opcode;
   logic       cb_prefix;
   logic       isr_cmd;
   control_t   ctrl;
   logic [2:0] m_cycle;
   logic       instr_done;
   logic       int_ack;

   modport master (
      input  schedule, mem_rdata, int_pending, ime,
      output opcode, cb_prefix, isr_cmd, ctrl,
      output m_cycle, instr_done, int_ack
   );

   modport slave (
      output schedule, mem_rdata, int_pending, ime,
      input  opcode, cb_prefix, isr_cmd, ctrl,
      input  m_cycle, instr_done, int_ack
   );

endinterface

// File: rtl/gb_cpu_sequencer.sv
// gb_cpu_sequencer: steps through the decoder schedule one M-cycle per clk,
// fetches the next opcode on the last M-cycle, inserts the ISR at
// instruction boundaries and (with GB_CPU_HALT_EN defined) supports HALT.
// Ports: clk, reset (sync, active-high), bus (gb_cpu_sequencer_if.master):
//   in  schedule, mem_rdata, int_pending, ime
//   out opcode, cb_prefix, isr_cmd, ctrl, m_cycle, instr_done, int_ack
module gb_cpu_sequencer #(
   parameter int MAX_M_CYCLES = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   gb_cpu_sequencer_if.master        bus
);
   import gb_cpu_common_pkg::*;

   localparam logic [2:0] SAT_IDX = 3'(MAX_M_CYCLES - 1);

   logic [7:0] opcode, opcode_nxt;
   logic       cb_prefix, cb_nxt;
   logic       isr_cmd, isr_nxt;
   logic [2:0] m_cycle, m_nxt;
   control_t   ctrl;
   logic       done;
   logic       ack;
   logic       cb_bnd;
   logic       halted;

`ifdef GB_CPU_HALT_EN
   seq_state_t state, state_nxt;
   assign halted = (state == HALT);
`else
   assign halted = 1'b0;
`endif

   always_comb begin
      opcode_nxt = opcode;
      cb_nxt     = cb_prefix;
      isr_nxt    = isr_cmd;
      m_nxt      = m_cycle;
`ifdef GB_CPU_HALT_EN
      state_nxt  = state;
`endif
      ctrl       = '0;
      done       = 1'b0;
      ack        = 1'b0;
      // The ISR keeps a stale opcode, so it never opens a CB pair.
      cb_bnd     = !isr_cmd && (opcode == 8'hCB) && !cb_prefix;

      if (halted) begin
`ifdef GB_CPU_HALT_EN
         m_nxt = 3'd0;
         if (bus.int_pending) begin
            state_nxt  = EXEC;
            opcode_nxt = 8'h00;
            cb_nxt     = 1'b0;
            isr_nxt    = bus.ime;
         end
`endif
      end else begin
         ctrl = bus.schedule.m_cycles[m_cycle];
         done = (m_cycle == last_index(bus.schedule.num_m_cycles))
             || (m_cycle == SAT_IDX);
         ack  = isr_cmd && done;
         if (!done) begin
            m_nxt = 3'(m_cycle + 3'd1);
         end else begin
            m_nxt   = 3'd0;
            cb_nxt  = cb_bnd;
            isr_nxt = bus.int_pending && bus.ime && !cb_bnd;
            if (!isr_cmd) opcode_nxt = bus.mem_rdata;
`ifdef GB_CPU_HALT_EN
            if ((opcode == 8'h76) && !cb_prefix && !isr_cmd) begin
               state_nxt  = HALT;
               opcode_nxt = opcode;
               cb_nxt     = 1'b0;
               isr_nxt    = 1'b0;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         opcode    <= 8'h00;
         cb_prefix <= 1'b0;
         isr_cmd   <= 1'b0;
         m_cycle   <= 3'd0;
`ifdef GB_CPU_HALT_EN
         state     <= EXEC;
`endif
      end else begin
         opcode    <= opcode_nxt;
         cb_prefix <= cb_nxt;
         isr_cmd   <= isr_nxt;
         m_cycle   <= m_nxt;
`ifdef GB_CPU_HALT_EN
         state     <= state_nxt;
`endif
      end
   end

   assign bus.opcode     = opcode;
   assign bus.cb_prefix  = cb_prefix;
   assign bus.isr_cmd    = isr_cmd;
   assign bus.ctrl       = ctrl;
   assign bus.m_cycle    = m_cycle;
   assign bus.instr_done = done;
   assign bus.int_ack    = ack;

endmodule

// File: tb/tb_gb_cpu_sequencer.sv
// Self-checking bench for gb_cpu_sequencer: directed scenarios plus
// randomized traffic against an instruction-level reference model.
module tb_gb_cpu_sequencer;
   import gb_cpu_common_pkg::*;

   localparam int MAXM = MAX_M_CYCLES;
`ifdef GB_CPU_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   gb_cpu_sequencer_if bus();

   gb_cpu_sequencer #(.MAX_M_CYCLES(MAXM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   schedule_t tbl [0:511];
   schedule_t isr_sched;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   logic [7:0] md_op;
   bit         md_cb, md_isr, md_halt;
   int         md_m;

   task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   function automatic schedule_t cur_sched();
      if (md_isr) return isr_sched;
      return tbl[{md_cb, md_op}];
   endfunction

   function automatic int span(schedule_t s);
      int n;
      n = (s.num_m_cycles == 3'd0) ? 1 : int'(s.num_m_cycles);
      return (n > MAXM) ? MAXM : n;
   endfunction

   task automatic compare();
      schedule_t  s;
      logic [15:0] e_ctrl;
      bit          e_done;
      s = cur_sched();
      if (md_halt) begin
         e_ctrl = 16'h0;
         e_done = 1'b0;
      end else begin
         e_ctrl = s.m_cycles[md_m];
         e_done = (md_m == span(s) - 1);
      end
      check("opcode", 32'(bus.opcode), 32'(md_op));
      check("cb_prefix", 32'(bus.cb_prefix), 32'(md_cb));
      check("isr_cmd", 32'(bus.isr_cmd), 32'(md_isr));
      check("m_cycle", 32'(bus.m_cycle), 32'(md_m));
      check("ctrl", 32'(bus.ctrl), 32'(e_ctrl));
      check("instr_done", 32'(bus.instr_done), 32'(e_done));
      check("int_ack", 32'(bus.int_ack), 32'(md_isr && e_done));
   endtask

   task automatic step(bit rst, logic [7:0] rd, bit ip, bit ie);
      schedule_t s;
      bit        cbn;
      s = cur_sched();
      if (rst) begin
         md_op = 8'h00; md_cb = 0; md_isr = 0; md_halt = 0; md_m = 0;
      end else if (md_halt) begin
         if (ip) begin
            md_halt = 0; md_op = 8'h00; md_cb = 0; md_isr = ie;
         end
      end else if (md_m < span(s) - 1) begin
         md_m++;
      end else begin
         md_m = 0;
         if (HALT_EN && md_op == 8'h76 && !md_cb && !md_isr) begin
            md_halt = 1; md_cb = 0; md_isr = 0;
         end else begin
            cbn = !md_isr && md_op == 8'hCB && !md_cb;
            if (!md_isr) md_op = rd;
            md_cb  = cbn;
            md_isr = ip && ie && !cbn;
         end
      end
   endtask

   logic [7:0] cur_rd;
   bit         cur_rst, cur_ip, cur_ie;

   task automatic apply(bit rst, logic [7:0] rd, bit ip, bit ie);
      cur_rst = rst; cur_rd = rd; cur_ip = ip; cur_ie = ie;
      reset           = rst;
      bus.mem_rdata   = rd;
      bus.int_pending = ip;
      bus.ime         = ie;
      bus.schedule    = cur_sched();
      @(negedge clk);
      if (chk_en) compare();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      step(cur_rst, cur_rd, cur_ip, cur_ie);
      chk_en = 1'b1;
   endtask

   task automatic set_len(int idx, logic [2:0] n);
      tbl[idx].num_m_cycles = n;
   endtask

   initial begin
      logic [15:0] r16;
      md_op = 8'h00; md_cb = 0; md_isr = 0; md_halt = 0; md_m = 0;
      for (int i = 0; i < 512; i++) begin
         tbl[i].num_m_cycles = 3'($urandom_range(0, 7));
         for (int j = 0; j < MAXM; j++) begin
            r16 = 16'($urandom);
            tbl[i].m_cycles[j] = control_t'(r16);
         end
      end
      isr_sched.num_m_cycles = 3'd5;
      for (int j = 0; j < MAXM; j++) begin
         r16 = 16'($urandom);
         isr_sched.m_cycles[j] = control_t'(r16);
      end
      set_len(9'h000, 3'd1);
      set_len(9'h03C, 3'd1);
      set_len(9'h080, 3'd1);
      set_len(9'h0CB, 3'd1);
      set_len(9'h137, 3'd2);
      set_len(9'h011, 3'd3);
      set_len(9'h022, 3'd4);
      set_len(9'h076, 3'd2);

      // Reset then plain 1-M-cycle fetch stream.
      apply(1, 8'h00, 0, 0); advance();
      apply(0, 8'h3C, 0, 0);
      check("rst_opcode", 32'(bus.opcode), 32'h00);
      check("rst_done", 32'(bus.instr_done), 32'h1);
      check("rst_m", 32'(bus.m_cycle), 32'h0);
      check("rst_ack", 32'(bus.int_ack), 32'h0);
      advance();
      apply(0, 8'h80, 0, 0);
      check("f_3c", 32'(bus.opcode), 32'h3C);
      check("f_3c_done", 32'(bus.instr_done), 32'h1);
      advance();
      apply(0, 8'h00, 0, 0);
      check("f_80", 32'(bus.opcode), 32'h80);
      check("f_80_done", 32'(bus.instr_done), 32'h1);
      advance();

      // CB prefix pair.
      apply(0, 8'hCB, 0, 0); advance();
      apply(0, 8'h37, 0, 0);
      check("cb_op", 32'(bus.opcode), 32'hCB);
      check("cb_flag0", 32'(bus.cb_prefix), 32'h0);
      advance();
      apply(0, 8'h11, 1, 1);
      check("cb37_op", 32'(bus.opcode), 32'h37);
      check("cb37_flag", 32'(bus.cb_prefix), 32'h1);
      check("cb37_done", 32'(bus.instr_done), 32'h0);
      advance();
      apply(0, 8'h11, 0, 0);
      check("cb37_m1", 32'(bus.m_cycle), 32'h1);
      check("cb37_isr", 32'(bus.isr_cmd), 32'h0);
      advance();

      // Interrupt raised mid-instruction waits for the boundary.
      apply(0, 8'h00, 0, 1);
      check("i_op", 32'(bus.opcode), 32'h11);
      check("i_cb_clr", 32'(bus.cb_prefix), 32'h0);
      advance();
      apply(0, 8'h00, 1, 1);
      check("i_m1", 32'(bus.m_cycle), 32'h1);
      check("i_m1_isr", 32'(bus.isr_cmd), 32'h0);
      advance();
      apply(0, 8'h3C, 1, 1);
      check("i_m2_done", 32'(bus.instr_done), 32'h1);
      check("i_m2_isr", 32'(bus.isr_cmd), 32'h0);
      advance();
      apply(0, 8'h00, 0, 1);
      check("isr_on", 32'(bus.isr_cmd), 32'h1);
      check("isr_op", 32'(bus.opcode), 32'h3C);
      check("isr_ack0", 32'(bus.int_ack), 32'h0);
      advance();
      for (int k = 1; k < 4; k++) begin
         apply(0, 8'h00, 0, 1); advance();
      end
      apply(0, 8'h00, 0, 1);
      check("isr_last", 32'(bus.m_cycle), 32'h4);
      check("isr_ack", 32'(bus.int_ack), 32'h1);
      advance();
      apply(0, 8'h22, 0, 0);
      check("isr_off", 32'(bus.isr_cmd), 32'h0);
      check("isr_ack_off", 32'(bus.int_ack), 32'h0);
      check("refetch_op", 32'(bus.opcode), 32'h3C);
      advance();

      // Reset in the middle of a 4-M-cycle instruction.
      apply(0, 8'h00, 0, 0);
      check("r4_op", 32'(bus.opcode), 32'h22);
      advance();
      apply(0, 8'h00, 0, 0); advance();
      apply(1, 8'h00, 0, 0);
      check("r4_m2", 32'(bus.m_cycle), 32'h2);
      advance();
      apply(0, 8'h00, 0, 0);
      check("r4_op0", 32'(bus.opcode), 32'h00);
      check("r4_mc0", 32'(bus.m_cycle), 32'h0);
      advance();

`ifdef GB_CPU_HALT_EN
      for (int rep = 0; rep < 2; rep++) begin
         apply(0, 8'h76, 0, 0); advance();
         apply(0, 8'h00, 0, 0);
         check("h_op", 32'(bus.opcode), 32'h76);
         advance();
         apply(0, 8'h00, 0, 0); advance();
         for (int k = 0; k < 10; k++) begin
            apply(0, 8'h55, 0, 0);
            check("h_ctrl", 32'(bus.ctrl), 32'h0);
            check("h_done", 32'(bus.instr_done), 32'h0);
            advance();
         end
         apply(0, 8'h55, 1, rep[0]);
         check("h_m", 32'(bus.m_cycle), 32'h0);
         advance();
         apply(0, 8'h00, 0, 0);
         check("hx_op", 32'(bus.opcode), 32'h00);
         check("hx_isr", 32'(bus.isr_cmd), 32'(rep));
         check("hx_done", 32'(bus.instr_done), rep ? 32'h0 : 32'h1);
         advance();
         while (md_isr || md_m != 0) begin
            apply(0, 8'h00, 0, 0); advance();
         end
      end
`else
      apply(0, 8'h76, 0, 0); advance();
      apply(0, 8'h00, 0, 0);
      check("n76_op", 32'(bus.opcode), 32'h76);
      check("n76_c0", 32'(bus.ctrl), 32'(tbl[9'h076].m_cycles[0]));
      advance();
      apply(0, 8'hAA, 0, 0);
      check("n76_c1", 32'(bus.ctrl), 32'(tbl[9'h076].m_cycles[1]));
      check("n76_done", 32'(bus.instr_done), 32'h1);
      advance();
      apply(0, 8'h00, 0, 0);
      check("n76_next", 32'(bus.opcode), 32'hAA);
      check("n76_m0", 32'(bus.m_cycle), 32'h0);
      advance();
`endif

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         logic [7:0] rd;
         int         sel;
         sel = int'($urandom_range(0, 9));
         rd  = 8'($urandom);
         if (sel == 0) rd = 8'hCB;
         else if (sel == 1) rd = 8'h76;
         apply(($urandom_range(0, 199) == 0), rd,
               ($urandom_range(0, 7) == 0), 1'($urandom));
         advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gb_cpu_sequencer.md
GB_CPU_SEQUENCER -- requirements
Module: gb_cpu_sequencer

Interface
REQ-001 SHALL have parameter MAX_M_CYCLES, default 6: depth of the schedule_t M-cycle array.
REQ-002 SHALL have port clk  input  1  CPU clock; one rising edge per M-cycle.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port schedule  input  schedule_t  schedule from gb_cpu_decoder for the current opcode, cb_prefix and isr_cmd.
REQ-005 SHALL have port mem_rdata  input  8  memory read data; holds the next opcode byte on the final M-cycle of each instruction.
REQ-006 SHALL have port int_pending  input  1  (IE & IF) != 0.
REQ-007 SHALL have port ime  input  1  interrupt master enable.
REQ-008 SHALL have port opcode  output  8  instruction register; drives the decoder.
REQ-009 SHALL have port cb_prefix  output  1  current instruction is 0xCB-prefixed.
REQ-010 SHALL have port isr_cmd  output  1  current "instruction" is the ISR.
REQ-011 SHALL have port ctrl  output  control_t  control word for the current M-cycle.
REQ-012 SHALL have port m_cycle  output  3  index of the current M-cycle within the instruction.
REQ-013 SHALL have port instr_done  output  1  current M-cycle is the last of the instruction.
REQ-014 SHALL have port int_ack  output  1  one-cycle pulse when an ISR completes.

Function
REQ-015 States: EXEC, HALT.
REQ-016 In EXEC, ctrl SHALL equal schedule.m_cycles[m_cycle].
REQ-017 In HALT, ctrl SHALL equal the all-zero idle control word.
REQ-018 In EXEC, instr_done SHALL be 1 when m_cycle == schedule.num_m_cycles-1; num_m_cycles==0 is treated as 1.
REQ-019 The m_cycle counter SHALL increment each clk while not instr_done, and SHALL return to 0 on the edge following instr_done.
REQ-020 The counter SHALL saturate at MAX_M_CYCLES-1 and force instr_done.
REQ-021 Boundary (edge after instr_done): when isr_cmd=0, opcode SHALL load mem_rdata; the fetch overlaps the last M-cycle, so a 1-M-cycle instruction occupies exactly one clk.
REQ-022 Boundary: next cb_prefix SHALL = (opcode==8'hCB && !cb_prefix); cb_prefix SHALL clear at every other boundary.
REQ-023 Boundary: next isr_cmd SHALL = (int_pending && ime && next cb_prefix==0), i.e. no ISR between 0xCB and its operand.
REQ-024 When the ISR is entered, opcode SHALL keep the value loaded at that boundary; the ISR schedule does not advance PC, so that opcode is re-fetched after the ISR.
REQ-025 At ISR completion, int_ack SHALL pulse for one cycle coincident with instr_done, and isr_cmd SHALL clear.
REQ-026 Nested ISR check applies at the ISR's own boundary as for any instruction.
REQ-027 HALT entry: on the last M-cycle of opcode 8'h76 with cb_prefix=0, the next state SHALL be HALT, and opcode SHALL NOT load.
REQ-028 In HALT: m_cycle=0, instr_done=0.
REQ-029 HALT exit: on int_pending=1, independent of ime, the next state SHALL be EXEC.
REQ-030 HALT exit with ime=1: isr_cmd SHALL set.
REQ-031 HALT exit with ime=0: opcode SHALL load 8'h00 (NOP), whose single fetch M-cycle resumes normal flow.
REQ-032 Simultaneous instr_done and int_pending SHALL be evaluated at that same boundary.
REQ-033 int_pending asserted mid-instruction SHALL be ignored until the boundary.

Reset
REQ-034 On reset, the sequencer SHALL set state=EXEC, opcode=8'h00, cb_prefix=0, isr_cmd=0, m_cycle=0, int_ack=0.
REQ-035 On reset, instr_done SHALL be 1 because the NOP schedule has 1 M-cycle, so the first edge after reset deasserts fetches the first opcode.
REQ-036 Reset asserted mid-instruction or in HALT SHALL abandon the current state immediately on the next edge.

Configuration
REQ-037 The macro GB_CPU_HALT_EN SHALL compile HALT support in or out.
REQ-038 With GB_CPU_HALT_EN defined, the HALT state and REQ-027 to REQ-031 SHALL be present.
REQ-039 Without GB_CPU_HALT_EN, the HALT state SHALL be absent and 8'h76 SHALL sequence as an ordinary instruction using the decoder schedule.

Structure
REQ-040 control_t, schedule_t (num_m_cycles plus m_cycles[MAX_M_CYCLES]) and the MAX_M_CYCLES constant SHALL live in gb_cpu_common_pkg.
REQ-041 The sequencer state enum seq_state_t SHALL live in gb_cpu_common_pkg.
REQ-042 The sequencer SHALL contain no sub-module; gb_cpu_decoder SHALL be instantiated beside it at CPU top, with opcode/cb_prefix/isr_cmd → decoder and schedule → sequencer.

Verification
REQ-043 Reset, then feed mem_rdata = 8'h3C then 8'h80 → opcode=8'h00 for 1 clk, then 8'h3C for 1 clk, then 8'h80; instr_done=1 every clk.
REQ-044 Feed 8'hCB then 8'h37 → at the boundary, opcode=8'h37 and cb_prefix=1 for exactly that instruction, then 0.
REQ-045 Run a 3-M-cycle schedule with int_pending rising at m_cycle=1, ime=1 → no disturbance until m_cycle=2; then isr_cmd=1 and opcode unchanged; int_ack pulses on the ISR's last M-cycle.
REQ-046 Execute 8'h76, then raise int_pending after 10 clks with ime=0 → HALT for 10 clks with ctrl idle; then opcode=8'h00, EXEC, and isr_cmd=0. Repeat with ime=1 → isr_cmd=1.
REQ-047 Assert reset at m_cycle=2 of a 4-M-cycle schedule → next clk opcode=8'h00, m_cycle=0.
REQ-048 Build without GB_CPU_HALT_EN and execute 8'h76 → never enters HALT; ctrl follows the decoder schedule.
